// File: rtl/acc_ctrl_pkg.sv
// Shared types and constants for the accumulator-machine control unit.
package acc_ctrl_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned ALU_W = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_IDLE   = 4'd1,
        ST_FETCH  = 4'd2,
        ST_DECODE = 4'd3,
        ST_MEM_RD = 4'd4,
        ST_LD_AB  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_WB_ALU = 4'd7,
        ST_WB_LDA = 4'd8,
        ST_STORE  = 4'd9,
        ST_JUMP   = 4'd10
    } state_e;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_NOT = 3'b011;
    localparam logic [OP_W-1:0] OP_LDA = 3'b100;
    localparam logic [OP_W-1:0] OP_STA = 3'b101;
    localparam logic [OP_W-1:0] OP_JMP = 3'b110;
    localparam logic [OP_W-1:0] OP_JZ  = 3'b111;

    localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_W-1:0] ALU_NOT = 2'b11;

    // Mux selects: 0 picks the first datapath input, 1 the second.
    localparam logic SEL_PC  = 1'b0;
    localparam logic SEL_IR  = 1'b1;
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MDR = 1'b1;
    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_PCX = 1'b1;
    localparam logic SEL_B   = 1'b0;
    localparam logic SEL_ONE = 1'b1;

    typedef struct packed {
        logic             pc_init;
        logic             pc_write;
        logic             pc_write_cond;
        logic             pc_src;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             ld_acc;
        logic             acc_src;
        logic             ld_a;
        logic             ld_b;
        logic             a_src;
        logic             b_src;
        logic [ALU_W-1:0] alu_op;
        logic             busy;
        logic             instr_done;
    } ctrl_t;

endpackage

// File: rtl/acc_ctrl_outdec.sv
// Moore control-vector decoder: state (plus latched IR opcode) -> datapath strobes.
module acc_ctrl_outdec
    import acc_ctrl_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] opcode_i,
    output ctrl_t           ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        unique case (state_i)
            ST_INIT: ctrl_c.pc_init = 1'b1;
            ST_IDLE: ;
            ST_FETCH: begin
                ctrl_c.i_or_d   = SEL_PC;
                ctrl_c.mem_read = 1'b1;
                ctrl_c.ir_write = 1'b1;
                ctrl_c.a_src    = SEL_PCX;
                ctrl_c.b_src    = SEL_ONE;
                ctrl_c.alu_op   = ALU_ADD;
                ctrl_c.pc_src   = SEL_ALU;
                ctrl_c.pc_write = 1'b1;
                ctrl_c.busy     = 1'b1;
            end
            ST_DECODE: ctrl_c.busy = 1'b1;
            ST_MEM_RD: begin
                ctrl_c.i_or_d   = SEL_IR;
                ctrl_c.mem_read = 1'b1;
                ctrl_c.busy     = 1'b1;
            end
            ST_LD_AB: begin
                ctrl_c.ld_a = 1'b1;
                ctrl_c.ld_b = 1'b1;
                ctrl_c.busy = 1'b1;
            end
            ST_EXEC: begin
                ctrl_c.a_src  = SEL_A;
                ctrl_c.b_src  = SEL_B;
                ctrl_c.alu_op = opcode_i[ALU_W-1:0];
                ctrl_c.busy   = 1'b1;
            end
            ST_WB_ALU: begin
                ctrl_c.acc_src    = SEL_ALU;
                ctrl_c.ld_acc     = 1'b1;
                ctrl_c.alu_op     = opcode_i[ALU_W-1:0];
                ctrl_c.busy       = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_WB_LDA: begin
                ctrl_c.acc_src    = SEL_MDR;
                ctrl_c.ld_acc     = 1'b1;
                ctrl_c.busy       = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_STORE: begin
                ctrl_c.i_or_d     = SEL_IR;
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.busy       = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl_c.pc_src        = SEL_IR;
                ctrl_c.pc_write      = (opcode_i == OP_JMP);
                ctrl_c.pc_write_cond = (opcode_i == OP_JZ);
                ctrl_c.busy          = 1'b1;
                ctrl_c.instr_done    = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/acc_controller.sv
// Multi-cycle sequencer for the accumulator datapath: start-up, run gating and instruction flow.
module acc_controller
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned OPW         = OP_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PC_init,
    output logic           PCwrite,
    output logic           PCwrite_cond,
    output logic           PCsrc,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRwrite,
    output logic           ldACC,
    output logic           ACCsrc,
    output logic           ldA,
    output logic           ldB,
    output logic           Asrc,
    output logic           Bsrc,
    output logic [1:0]     ALUop,
    output logic           busy,
    output logic           instr_done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_c;

    // The branch condition is applied in the datapath through PCwrite_cond.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // run is only looked at on instruction boundaries (end of INIT, IDLE, last state).
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_LDA: state_d = ST_MEM_RD;
                    OP_NOT:                         state_d = ST_LD_AB;
                    OP_STA:                         state_d = ST_STORE;
                    default:                        state_d = ST_JUMP;
                endcase
            end
            ST_MEM_RD: state_d = (opcode == OP_LDA) ? ST_WB_LDA : ST_LD_AB;
            ST_LD_AB:  state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB_ALU;
            ST_WB_ALU, ST_WB_LDA, ST_STORE, ST_JUMP:
                state_d = run ? ST_FETCH : ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    acc_ctrl_outdec u_outdec (
        .state_i  (state_q),
        .opcode_i (opcode),
        .ctrl_c   (ctrl_c)
    );

    assign PC_init      = ctrl_c.pc_init;
    assign PCwrite      = ctrl_c.pc_write;
    assign PCwrite_cond = ctrl_c.pc_write_cond;
    assign PCsrc        = ctrl_c.pc_src;
    assign IorD         = ctrl_c.i_or_d;
    assign MemRead      = ctrl_c.mem_read;
    assign MemWrite     = ctrl_c.mem_write;
    assign IRwrite      = ctrl_c.ir_write;
    assign ldACC        = ctrl_c.ld_acc;
    assign ACCsrc       = ctrl_c.acc_src;
    assign ldA          = ctrl_c.ld_a;
    assign ldB          = ctrl_c.ld_b;
    assign Asrc         = ctrl_c.a_src;
    assign Bsrc         = ctrl_c.b_src;
    assign ALUop        = ctrl_c.alu_op;
    assign busy         = ctrl_c.busy;
    assign instr_done   = ctrl_c.instr_done;

endmodule

// File: tb/tb_acc_controller.sv
// Directed bench for acc_controller: hand-written per-cycle control vectors for each instruction class.
module tb_acc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [2:0] opcode;
    logic       zero;
    logic       PC_init, PCwrite, PCwrite_cond, PCsrc, IorD, MemRead, MemWrite, IRwrite;
    logic       ldACC, ACCsrc, ldA, ldB, Asrc, Bsrc, busy, instr_done;
    logic [1:0] ALUop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acc_controller #(.INIT_CYCLES(2), .OPW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .opcode       (opcode),
        .zero         (zero),
        .PC_init      (PC_init),
        .PCwrite      (PCwrite),
        .PCwrite_cond (PCwrite_cond),
        .PCsrc        (PCsrc),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRwrite      (IRwrite),
        .ldACC        (ldACC),
        .ACCsrc       (ACCsrc),
        .ldA          (ldA),
        .ldB          (ldB),
        .Asrc         (Asrc),
        .Bsrc         (Bsrc),
        .ALUop        (ALUop),
        .busy         (busy),
        .instr_done   (instr_done)
    );

    // {PC_init PCwrite PCwrite_cond PCsrc}_{IorD MemRead MemWrite IRwrite}_
    // {ldACC ACCsrc ldA ldB}_{Asrc Bsrc ALUop}_{busy instr_done}
    logic [17:0] obs;
    assign obs = {PC_init, PCwrite, PCwrite_cond, PCsrc, IorD, MemRead, MemWrite, IRwrite,
                  ldACC, ACCsrc, ldA, ldB, Asrc, Bsrc, ALUop, busy, instr_done};

    localparam logic [17:0] V_INIT   = 18'b1000_0000_0000_0000_00;
    localparam logic [17:0] V_IDLE   = 18'b0000_0000_0000_0000_00;
    localparam logic [17:0] V_FETCH  = 18'b0100_0101_0000_1100_10;
    localparam logic [17:0] V_DECODE = 18'b0000_0000_0000_0000_10;
    localparam logic [17:0] V_MEMRD  = 18'b0000_1100_0000_0000_10;
    localparam logic [17:0] V_LDAB   = 18'b0000_0000_0011_0000_10;
    localparam logic [17:0] V_EXEC   = 18'b0000_0000_0000_0000_10;
    localparam logic [17:0] V_WBALU  = 18'b0000_0000_1000_0000_11;
    localparam logic [17:0] V_WBLDA  = 18'b0000_0000_1100_0000_11;
    localparam logic [17:0] V_STORE  = 18'b0000_1010_0000_0000_11;
    localparam logic [17:0] V_JMP    = 18'b0101_0000_0000_0000_11;
    localparam logic [17:0] V_JZ     = 18'b0011_0000_0000_0000_11;

    function automatic logic [17:0] with_alu(input logic [17:0] v, input logic [1:0] a);
        return v | {14'b0, a, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of the stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        run    = 1'b1;
        opcode = 3'b001;
        zero   = 1'b0;

        // Reset and start-up
        repeat (3) expect_cyc("in_reset", V_INIT);
        rst_n = 1'b1;
        #1 check("init_after_release", 32'(obs), 32'(V_INIT));
        expect_cyc("init_cycle2", V_INIT);
        expect_cyc("first_fetch", V_FETCH);

        // SUB: 6 cycles
        expect_cyc("sub_decode", V_DECODE);
        expect_cyc("sub_memrd", V_MEMRD);
        expect_cyc("sub_ldab", V_LDAB);
        expect_cyc("sub_exec", with_alu(V_EXEC, 2'b01));
        expect_cyc("sub_wb", with_alu(V_WBALU, 2'b01));

        // LDA: 4 cycles
        expect_cyc("lda_fetch", V_FETCH);
        opcode = 3'b100;
        expect_cyc("lda_decode", V_DECODE);
        expect_cyc("lda_memrd", V_MEMRD);
        expect_cyc("lda_wb", V_WBLDA);

        // STA: 3 cycles
        expect_cyc("sta_fetch", V_FETCH);
        opcode = 3'b101;
        expect_cyc("sta_decode", V_DECODE);
        expect_cyc("sta_store", V_STORE);

        // JZ with zero low, then zero high: strobes identical
        expect_cyc("jz0_fetch", V_FETCH);
        opcode = 3'b111;
        zero   = 1'b0;
        expect_cyc("jz0_decode", V_DECODE);
        expect_cyc("jz0_jump", V_JZ);
        expect_cyc("jz1_fetch", V_FETCH);
        zero = 1'b1;
        expect_cyc("jz1_decode", V_DECODE);
        expect_cyc("jz1_jump", V_JZ);

        // JMP
        expect_cyc("jmp_fetch", V_FETCH);
        opcode = 3'b110;
        zero   = 1'b0;
        expect_cyc("jmp_decode", V_DECODE);
        expect_cyc("jmp_jump", V_JMP);

        // NOT: 5 cycles, skips memory
        expect_cyc("not_fetch", V_FETCH);
        opcode = 3'b011;
        expect_cyc("not_decode", V_DECODE);
        expect_cyc("not_ldab", V_LDAB);
        expect_cyc("not_exec", with_alu(V_EXEC, 2'b11));
        expect_cyc("not_wb", with_alu(V_WBALU, 2'b11));

        // ADD with run dropped during EXEC
        expect_cyc("add_fetch", V_FETCH);
        opcode = 3'b000;
        expect_cyc("add_decode", V_DECODE);
        expect_cyc("add_memrd", V_MEMRD);
        expect_cyc("add_ldab", V_LDAB);
        expect_cyc("add_exec", V_EXEC);
        run = 1'b0;
        expect_cyc("add_wb", V_WBALU);
        expect_cyc("stop_idle1", V_IDLE);
        check("idle_busy", 32'(busy), 32'd0);
        expect_cyc("stop_idle2", V_IDLE);
        run = 1'b1;
        expect_cyc("resume_fetch", V_FETCH);

        // Reset asserted in the middle of STORE
        opcode = 3'b101;
        expect_cyc("sta2_decode", V_DECODE);
        expect_cyc("sta2_store", V_STORE);
        #1 rst_n = 1'b0;
        #1 check("memwrite_abort", 32'(MemWrite), 32'd0);
        check("async_init", 32'(obs), 32'(V_INIT));

        // Start-up with run low lands in IDLE
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_cyc("init2_cycle2", V_INIT);
        expect_cyc("init2_idle", V_IDLE);
        run = 1'b1;
        expect_cyc("idle_to_fetch", V_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_controller.md
Name: acc_controller

Overview:
Multi-cycle FSM controller that sequences the accumulator datapath (PC, IR, MDR, A/B, ALU_Reg, ACC, single memory port).
- Consumes opcode and the ACC zero flag.
- Drives every datapath control strobe, one state per cycle (Moore outputs).
- Also owns datapath start-up: PC_init pulse, plus run/idle gating and an instruction-retired pulse.

Parameters:
INIT_CYCLES, 2, cycles PC_init is held after reset release (1..15)
OPW, 3, opcode width (fixed 3; present for package consistency)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = fetch and execute, 0 = stop at next instruction boundary
opcode  in  3  IR[15:13] from datapath
zero  in  1  ACC == 0 flag from datapath
PC_init  out  1  force PC to initial value
PCwrite  out  1  unconditional PC load
PCwrite_cond  out  1  PC load if zero
PCsrc  out  1  0 = ALU result, 1 = IR[12:0]
IorD  out  1  0 = address from PC, 1 = address from IR[12:0]
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable (data = ACC)
IRwrite  out  1  IR load
ldACC  out  1  ACC load
ACCsrc  out  1  0 = ALU_Reg, 1 = MDR
ldA  out  1  A register load
ldB  out  1  B register load
Asrc  out  1  0 = A, 1 = PC (sign-extended)
Bsrc  out  1  0 = B, 1 = constant 1
ALUop  out  2  00 add, 01 sub, 10 and, 11 not
busy  out  1  1 in any state except IDLE and INIT
instr_done  out  1  one-cycle pulse in the last state of each instruction

Behaviour:
- Mux conventions: sel=0 picks in1, sel=1 picks in2. Memory read data is valid combinationally in the cycle MemRead is high; IR/MDR capture at that cycle's end.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 LDA, 101 STA, 110 JMP, 111 JZ.
- Outputs are decoded from the state register only; any output not listed for a state is 0.
- Reset (rst_n low, asynchronous): state=INIT, init counter=0. PC_init=1; all other outputs 0; busy=0.
- INIT:
  - PC_init=1 for INIT_CYCLES cycles; counter increments each cycle.
  - On the last count: go to FETCH if run=1, else IDLE.
- IDLE: all outputs 0; go to FETCH when run=1.
- FETCH: IorD=0, MemRead, IRwrite, Asrc=1, Bsrc=1, ALUop=00, PCsrc=0, PCwrite (PC<=PC+1) -> DECODE.
- DECODE: no strobes. Next state by opcode:
  - ADD/SUB/AND/LDA -> MEM_RD
  - NOT -> LD_AB
  - STA -> STORE
  - JMP/JZ -> JUMP
- MEM_RD: IorD=1, MemRead (MDR captures). LDA -> WB_LDA; otherwise -> LD_AB.
- LD_AB: ldA, ldB -> EXEC.
- EXEC: Asrc=0, Bsrc=0, ALUop=opcode[1:0] (ALU_Reg captures) -> WB_ALU.
- WB_ALU: ACCsrc=0, ldACC, ALUop=opcode[1:0], instr_done -> END.
- WB_LDA: ACCsrc=1, ldACC, instr_done -> END.
- STORE: IorD=1, MemWrite, instr_done -> END.
- JUMP: PCsrc=1, instr_done. PCwrite if opcode=110; PCwrite_cond if opcode=111 -> END.
- END is combinational routing, not a state: next state = FETCH if run=1, else IDLE.
- Latency in cycles: ADD/SUB/AND 6; NOT 5; LDA 4; STA/JMP/JZ 3.
- Exclusivity invariants, never violated:
  - MemRead and MemWrite never both high.
  - PCwrite and PCwrite_cond never both high.
  - IRwrite only in FETCH.
- run deasserted mid-instruction: the instruction completes, then the FSM enters IDLE. run is never sampled inside an instruction.
- opcode is sampled only in DECODE and later states; the IR is stable after FETCH.
- Reset mid-instruction: immediate return to INIT. A memory write in progress is aborted (MemWrite drops asynchronously).
- Illegal state encoding: recover to INIT on the next clock.

Decomposition:
- Package acc_ctrl_pkg:
  - state enum (INIT, IDLE, FETCH, DECODE, MEM_RD, LD_AB, EXEC, WB_ALU, WB_LDA, STORE, JUMP)
  - opcode constants
  - ALUop constants
  - mux-select constants (SEL_PC/SEL_IR, SEL_ALU/SEL_MDR)
- Sub-module acc_ctrl_outdec: pure combinational state+opcode -> control-vector decoder.
- Top module holds the state register, init counter and next-state logic.

Test Plan:
- rst_n low 3 cycles then high, INIT_CYCLES=2, run=1 -> PC_init high during reset plus 2 cycles; FETCH on the 3rd cycle after release with MemRead=IRwrite=PCwrite=1, IorD=0, Asrc=Bsrc=1, ALUop=00.
- opcode=001 (SUB), run=1 -> state sequence FETCH, DECODE, MEM_RD, LD_AB, EXEC, WB_ALU; ALUop=01 in EXEC and WB_ALU; instr_done only in WB_ALU; 6 cycles.
- opcode=100 (LDA) then 101 (STA) -> LDA: ACCsrc=1 with ldACC in the 4th cycle; STA: MemWrite=1, IorD=1 in the 3rd cycle, MemRead=0 throughout STORE.
- opcode=111 (JZ) with zero=0, then zero=1 -> PCwrite_cond=1, PCsrc=1, PCwrite=0 in JUMP both times; opcode=110 -> PCwrite=1, PCwrite_cond=0.
- run dropped during EXEC of ADD -> WB_ALU still occurs, then IDLE with busy=0 and all strobes 0; run=1 again -> FETCH next cycle.
- rst_n asserted during STORE -> MemWrite falls without a clock edge; state INIT, PC_init=1.
